// File: rtl/axi_ic_pkg.sv
// Shared AXI interconnect definitions.
// Burst encodings, 4KB boundary width and split FSM states.
package axi_ic_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam int BOUNDARY_4KB_BITS = 12;

  typedef enum logic [1:0] {
    IDLE,
    SEND_1,
    SEND_2
  } split_state_e;

endpackage

// File: rtl/splitting_4kb_masker.sv
// 4KB crossing detector and per-half AxLEN calculator.
// mask_sel_i selects the second-half length.
module splitting_4kb_masker
  import axi_ic_pkg::*;
#(
  parameter int LEN_WIDTH  = 3,
  parameter int SIZE_WIDTH = 3
) (
  input  logic [BOUNDARY_4KB_BITS-1:0] addr_lo_i,
  input  logic [LEN_WIDTH-1:0]         len_i,
  input  logic [SIZE_WIDTH-1:0]        size_i,
  input  logic [1:0]                   burst_i,
  input  logic                         mask_sel_i,
  output logic [BOUNDARY_4KB_BITS:0]   end_o,
  output logic                         cross_o,
  output logic [LEN_WIDTH-1:0]         len_o
);

  localparam int BW = BOUNDARY_4KB_BITS + 1;

  logic [BW-1:0] bytes;
  logic [BW-1:0] room;
  logic [BW-1:0] first_beats;
  logic [BW-1:0] second_beats;

  assign bytes = (BW'(len_i) + BW'(1)) << size_i;
  assign end_o = {1'b0, addr_lo_i} + bytes;

  // Bytes left before the boundary, and bytes spilling past it
  assign room = {1'b1, {BOUNDARY_4KB_BITS{1'b0}}} - {1'b0, addr_lo_i};
  assign first_beats  = room >> size_i;
  assign second_beats = {1'b0, end_o[BOUNDARY_4KB_BITS-1:0]} >> size_i;

  assign cross_o = (burst_i == BURST_INCR) && end_o[BOUNDARY_4KB_BITS];

  assign len_o = mask_sel_i ? LEN_WIDTH'(second_beats - BW'(1))
                            : LEN_WIDTH'(first_beats - BW'(1));

endmodule

// File: rtl/axi_4kb_split_ctrl.sv
// AXI address-channel sequencer that splits INCR bursts
// crossing a 4KB boundary into two tagged sub-requests.
module axi_4kb_split_ctrl
  import axi_ic_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 5,
  parameter int LEN_WIDTH  = 3,
  parameter int SIZE_WIDTH = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  ACLK_i,
  input  logic                  ARESET_i,
  input  logic [ID_WIDTH-1:0]   s_AxID_i,
  input  logic [ADDR_WIDTH-1:0] s_AxADDR_i,
  input  logic [LEN_WIDTH-1:0]  s_AxLEN_i,
  input  logic [SIZE_WIDTH-1:0] s_AxSIZE_i,
  input  logic [1:0]            s_AxBURST_i,
  input  logic                  s_AxVALID_i,
  output logic                  s_AxREADY_o,
  output logic [ID_WIDTH-1:0]   m_AxID_o,
  output logic [ADDR_WIDTH-1:0] m_AxADDR_o,
  output logic [LEN_WIDTH-1:0]  m_AxLEN_o,
  output logic [SIZE_WIDTH-1:0] m_AxSIZE_o,
  output logic [1:0]            m_AxBURST_o,
  output logic                  m_AxSPLIT_o,
  output logic                  m_AxVALID_o,
  input  logic                  m_AxREADY_i,
  output logic [CNT_WIDTH-1:0]  split_cnt_o
);

  localparam int PW = ADDR_WIDTH - BOUNDARY_4KB_BITS;
  localparam int MAX_BYTES =
    (1 << LEN_WIDTH) * (1 << ((1 << SIZE_WIDTH) - 1));

  if (MAX_BYTES > 4096) begin : g_bad_cfg
    $error("max burst exceeds 4KB; more than one crossing possible");
  end

  split_state_e state_q, state_d;

  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [SIZE_WIDTH-1:0] size_q;
  logic [1:0]            burst_q;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [BOUNDARY_4KB_BITS:0] end_w;
  logic                       cross_w;
  logic                       split_w;
  logic [LEN_WIDTH-1:0]       msk_len;
  logic                       m_hs;
  logic                       final_hs;
  logic                       accept;

  splitting_4kb_masker #(
    .LEN_WIDTH (LEN_WIDTH),
    .SIZE_WIDTH(SIZE_WIDTH)
  ) u_masker (
    .addr_lo_i (addr_q[BOUNDARY_4KB_BITS-1:0]),
    .len_i     (len_q),
    .size_i    (size_q),
    .burst_i   (burst_q),
    .mask_sel_i(state_q == SEND_2),
    .end_o     (end_w),
    .cross_o   (cross_w),
    .len_o     (msk_len)
  );

  // Ending exactly on the boundary does not need a second half
  assign split_w = cross_w && (end_w[BOUNDARY_4KB_BITS-1:0] != '0);

  assign m_AxVALID_o = (state_q != IDLE);
  assign m_hs        = m_AxVALID_o && m_AxREADY_i;
  assign final_hs    = m_hs && ((state_q == SEND_2) ||
                                ((state_q == SEND_1) && !split_w));
  assign s_AxREADY_o = (state_q == IDLE) || final_hs;
  assign accept      = s_AxVALID_i && s_AxREADY_o;

  assign m_AxID_o    = id_q;
  assign m_AxSIZE_o  = size_q;
  assign m_AxBURST_o = burst_q;
  assign split_cnt_o = cnt_q;

  always_comb begin
    m_AxADDR_o  = addr_q;
    m_AxLEN_o   = len_q;
    m_AxSPLIT_o = 1'b0;
    unique case (state_q)
      SEND_1: begin
        m_AxSPLIT_o = split_w;
        if (split_w) m_AxLEN_o = msk_len;
      end
      SEND_2: begin
        m_AxADDR_o = {addr_q[ADDR_WIDTH-1:BOUNDARY_4KB_BITS] + PW'(1),
                      {BOUNDARY_4KB_BITS{1'b0}}};
        m_AxLEN_o  = msk_len;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = SEND_1;
    end else if (final_hs) begin
      state_d = IDLE;
    end else if (m_hs && (state_q == SEND_1)) begin
      state_d = SEND_2;
    end
    if (m_hs && (state_q == SEND_1) && split_w && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        id_q    <= s_AxID_i;
        addr_q  <= s_AxADDR_i;
        len_q   <= s_AxLEN_i;
        size_q  <= s_AxSIZE_i;
        burst_q <= s_AxBURST_i;
      end
    end
  end

endmodule

// File: tb/tb_axi_4kb_split_ctrl.sv
// Bench for axi_4kb_split_ctrl: directed cases plus random
// requests checked against a byte-arithmetic reference model.
module tb_axi_4kb_split_ctrl;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  len;
    logic        split;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  s_id;
  logic [31:0] s_addr;
  logic [2:0]  s_len;
  logic [2:0]  s_size;
  logic [1:0]  s_burst;
  logic        s_valid;
  logic        s_ready;
  logic [4:0]  m_id;
  logic [31:0] m_addr;
  logic [2:0]  m_len;
  logic [2:0]  m_size;
  logic [1:0]  m_burst;
  logic        m_split;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] split_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int cnt_exp = 0;

  always #5 clk = ~clk;

  axi_4kb_split_ctrl dut (
    .ACLK_i      (clk),
    .ARESET_i    (rst),
    .s_AxID_i    (s_id),
    .s_AxADDR_i  (s_addr),
    .s_AxLEN_i   (s_len),
    .s_AxSIZE_i  (s_size),
    .s_AxBURST_i (s_burst),
    .s_AxVALID_i (s_valid),
    .s_AxREADY_o (s_ready),
    .m_AxID_o    (m_id),
    .m_AxADDR_o  (m_addr),
    .m_AxLEN_o   (m_len),
    .m_AxSIZE_o  (m_size),
    .m_AxBURST_o (m_burst),
    .m_AxSPLIT_o (m_split),
    .m_AxVALID_o (m_valid),
    .m_AxREADY_i (m_ready),
    .split_cnt_o (split_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: count whole beats that fit before the next 4KB page
  task automatic model(input logic [31:0] addr, input logic [2:0] len,
                       input logic [2:0] size, input logic [1:0] burst,
                       output int n, output beat_t b0, output beat_t b1);
    longint bpb   = longint'(1) << size;
    longint beats = longint'(len) + 1;
    longint off   = longint'(addr) % 4096;
    longint room  = (4096 - off) / bpb;
    b0.addr  = addr;
    b0.len   = len;
    b0.split = 1'b0;
    b1 = b0;
    n  = 1;
    if (burst == 2'b01 && beats > room) begin
      n        = 2;
      b0.len   = 3'(room - 1);
      b0.split = 1'b1;
      b1.addr  = 32'(((longint'(addr) >> 12) + 1) << 12);
      b1.len   = 3'(beats - room - 1);
      b1.split = 1'b0;
    end
  endtask

  task automatic check_beat(input string tag, input beat_t b,
                            input logic [4:0] id, input logic [2:0] size,
                            input logic [1:0] burst);
    chk({tag, ".valid"}, m_valid, 1'b1);
    chk({tag, ".id"},    m_id,    id);
    chk({tag, ".addr"},  m_addr,  b.addr);
    chk({tag, ".len"},   m_len,   b.len);
    chk({tag, ".size"},  m_size,  size);
    chk({tag, ".burst"}, m_burst, burst);
    chk({tag, ".split"}, m_split, b.split);
  endtask

  task automatic drive_req(input logic [4:0] id, input logic [31:0] addr,
                           input logic [2:0] len, input logic [2:0] size,
                           input logic [1:0] burst);
    s_valid = 1'b1;
    s_id    = id;
    s_addr  = addr;
    s_len   = len;
    s_size  = size;
    s_burst = burst;
  endtask

  task automatic run_req(input string tag, input logic [4:0] id,
                         input logic [31:0] addr, input logic [2:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int stall);
    int n;
    beat_t b0, b1, b;
    model(addr, len, size, burst, n, b0, b1);
    @(negedge clk);
    drive_req(id, addr, len, size, burst);
    m_ready = 1'b0;
    #1 chk({tag, ".s_ready_idle"}, s_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      b = (k == 0) ? b0 : b1;
      for (int s = 0; s < stall; s++) begin
        m_ready = 1'b0;
        #1;
        check_beat({tag, ".hold"}, b, id, size, burst);
        chk({tag, ".s_ready_hold"}, s_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
      end
      m_ready = 1'b1;
      #1;
      check_beat({tag, ".beat"}, b, id, size, burst);
      chk({tag, ".s_ready_hs"}, s_ready, (k == n - 1));
      if (b.split && cnt_exp < 65535) cnt_exp++;
      @(posedge clk);
      @(negedge clk);
    end
    m_ready = 1'b0;
    #1;
    chk({tag, ".done_valid"}, m_valid, 1'b0);
    chk({tag, ".split_cnt"}, split_cnt, 16'(cnt_exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b0, b1;
    int n;
    logic [31:0] bb_addr [4];
    logic [31:0] r_addr;
    logic [11:0] lo;
    logic [2:0]  r_size;
    logic [2:0]  r_len;
    logic [1:0]  r_burst;

    rst = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    drive_req(5'd0, 32'd0, 3'd0, 3'd0, 2'b00);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset.valid", m_valid, 1'b0);
    chk("reset.cnt", split_cnt, 16'd0);
    chk("reset.s_ready", s_ready, 1'b1);

    run_req("split_ff0", 5'd3, 32'h0000_0FF0, 3'd7, 3'd2, 2'b01, 0);
    run_req("exact_fe0", 5'd4, 32'h0000_0FE0, 3'd7, 3'd2, 2'b01, 0);
    run_req("wrap_ff8", 5'd5, 32'h0000_0FF8, 3'd3, 3'd2, 2'b10, 0);
    run_req("fixed_ff8", 5'd6, 32'h0000_0FF8, 3'd3, 3'd2, 2'b00, 0);
    run_req("stall", 5'd7, 32'h0000_5FF8, 3'd5, 3'd2, 2'b01, 3);
    run_req("topwrap", 5'd8, 32'hFFFF_FFC0, 3'd7, 3'd4, 2'b01, 1);

    bb_addr[0] = 32'h0000_0100;
    bb_addr[1] = 32'h0000_2204;
    bb_addr[2] = 32'h0000_0340;
    bb_addr[3] = 32'h0008_0400;
    @(negedge clk);
    m_ready = 1'b1;
    drive_req(5'd10, bb_addr[0], 3'd3, 3'd2, 2'b01);
    #1 chk("b2b.s_ready0", s_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i < 3) drive_req(5'(11 + i), bb_addr[i+1], 3'd3, 3'd2, 2'b01);
      else s_valid = 1'b0;
      #1;
      model(bb_addr[i], 3'd3, 3'd2, 2'b01, n, b0, b1);
      check_beat("b2b", b0, 5'(10 + i), 3'd2, 2'b01);
      chk("b2b.s_ready", s_ready, 1'b1);
    end
    @(posedge clk);
    @(negedge clk);
    m_ready = 1'b0;
    #1 chk("b2b.idle", m_valid, 1'b0);

    model(32'h0000_2FF0, 3'd7, 3'd2, 2'b01, n, b0, b1);
    @(negedge clk);
    drive_req(5'd20, 32'h0000_2FF0, 3'd7, 3'd2, 2'b01);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b1;
    #1 check_beat("rst2.first", b0, 5'd20, 3'd2, 2'b01);
    @(posedge clk);
    @(negedge clk);
    m_ready = 1'b0;
    #1 check_beat("rst2.second", b1, 5'd20, 3'd2, 2'b01);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst2.valid", m_valid, 1'b0);
    chk("rst2.cnt", split_cnt, 16'd0);
    chk("rst2.s_ready", s_ready, 1'b1);
    cnt_exp = 0;

    for (int i = 0; i < 40; i++) begin
      r_size  = 3'($urandom_range(0, 7));
      r_len   = 3'($urandom);
      r_burst = 2'($urandom_range(0, 2));
      r_addr  = $urandom;
      if (i % 3 != 0) begin
        lo = 12'(4096 - $urandom_range(1, 1100));
        r_addr[11:0] = lo;
      end
      if (i % 10 == 0) r_addr[31:12] = 20'hFFFFF;
      r_addr = r_addr & ~((32'd1 << r_size) - 32'd1);
      run_req("rand", 5'($urandom), r_addr, r_len, r_size, r_burst,
              $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
